// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct encodings, ALU operations and decode bundle
// shared by the single-cycle core and its ALU.
package cpu_pkg;

   localparam int IMEM_DEPTH_DEF = 64;
   localparam int DMEM_DEPTH_DEF = 64;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_LUI
   } alu_op_e;

   typedef struct packed {
      logic    reg_we;
      logic    dst_rd;
      logic    use_imm;
      logic    mem_rd;
      logic    mem_we;
      logic    beq;
      logic    bne;
      logic    jump;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '{
      reg_we:  1'b0,
      dst_rd:  1'b0,
      use_imm: 1'b0,
      mem_rd:  1'b0,
      mem_we:  1'b0,
      beq:     1'b0,
      bne:     1'b0,
      jump:    1'b0,
      alu_op:  ALU_ADD
   };

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 32-bit ALU; zero flag drives BEQ/BNE.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_e     op_i,
   output logic [31:0] result_o,
   output logic        zero_o
);

   always_comb begin
      result_o = '0;
      unique case (op_i)
         ALU_ADD: result_o = a_i + b_i;
         ALU_SUB: result_o = a_i - b_i;
         ALU_AND: result_o = a_i & b_i;
         ALU_OR:  result_o = a_i | b_i;
         ALU_SLT: result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         ALU_LUI: result_o = {b_i[15:0], 16'h0000};
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle MIPS-subset core with private instruction/data memories.
// Instruction memory is filled through the initialize port before running.
module cpu
   import cpu_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        initialize,
   input  logic [31:0] instruction_initialize_data,
   input  logic [31:0] instruction_initialize_address
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

   logic [31:0] imem_q [IMEM_DEPTH];
   logic [31:0] dmem_q [DMEM_DEPTH];
   logic [31:0] rf_q   [32];
   logic [31:0] pc_q;
   logic [31:0] pc_d;

   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic [25:0] target;

   logic is_rtype;
   logic is_addi;
   logic is_lui;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_bne;
   logic is_j;

   ctrl_t       ctrl;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic [31:0] imm_ext;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic [31:0] wb_val;
   logic [4:0]  wr_reg;
   logic [DAW-1:0] dm_idx;
   logic [IAW-1:0] im_wr_idx;
   logic [31:0] pc_plus4;
   logic [31:0] br_tgt;
   logic [31:0] pc_next;
   logic        br_taken;
   logic        run;
   logic        unused_ok;

   assign run   = ~initialize;
   assign instr = imem_q[pc_q[IAW+1:2]];

   assign op     = instr[31:26];
   assign rs     = instr[25:21];
   assign rt     = instr[20:16];
   assign rd     = instr[15:11];
   assign funct  = instr[5:0];
   assign imm16  = instr[15:0];
   assign target = instr[25:0];

   assign is_rtype = (op == OP_RTYPE);
   assign is_addi  = (op == OP_ADDI);
   assign is_lui   = (op == OP_LUI);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_bne   = (op == OP_BNE);
   assign is_j     = (op == OP_J);

   always_comb begin
      ctrl = CTRL_NOP;
      unique case (1'b1)
         is_rtype: begin
            ctrl.dst_rd = 1'b1;
            ctrl.reg_we = 1'b1;
            unique case (funct)
               FN_ADD:  ctrl.alu_op = ALU_ADD;
               FN_SUB:  ctrl.alu_op = ALU_SUB;
               FN_AND:  ctrl.alu_op = ALU_AND;
               FN_OR:   ctrl.alu_op = ALU_OR;
               FN_SLT:  ctrl.alu_op = ALU_SLT;
               default: ctrl.reg_we = 1'b0;
            endcase
         end
         is_addi: begin
            ctrl.reg_we  = 1'b1;
            ctrl.use_imm = 1'b1;
         end
         is_lui: begin
            ctrl.reg_we  = 1'b1;
            ctrl.use_imm = 1'b1;
            ctrl.alu_op  = ALU_LUI;
         end
         is_lw: begin
            ctrl.reg_we  = 1'b1;
            ctrl.use_imm = 1'b1;
            ctrl.mem_rd  = 1'b1;
         end
         is_sw: begin
            ctrl.use_imm = 1'b1;
            ctrl.mem_we  = 1'b1;
         end
         is_beq: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.beq    = 1'b1;
         end
         is_bne: begin
            ctrl.alu_op = ALU_SUB;
            ctrl.bne    = 1'b1;
         end
         is_j: begin
            ctrl.jump = 1'b1;
         end
         default: ;
      endcase
   end

   // R0 is hard-wired on the read side; its storage is never written.
   assign rs_val  = (rs == 5'd0) ? '0 : rf_q[rs];
   assign rt_val  = (rt == 5'd0) ? '0 : rf_q[rt];
   assign imm_ext = sext16(imm16);
   assign alu_b   = ctrl.use_imm ? imm_ext : rt_val;

   cpu_alu u_alu (
      .a_i      (rs_val),
      .b_i      (alu_b),
      .op_i     (ctrl.alu_op),
      .result_o (alu_res),
      .zero_o   (alu_zero)
   );

   assign dm_idx = alu_res[DAW+1:2];
   assign wb_val = ctrl.mem_rd ? dmem_q[dm_idx] : alu_res;
   assign wr_reg = ctrl.dst_rd ? rd : rt;

   assign pc_plus4 = pc_q + 32'd4;
   assign br_tgt   = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign br_taken = (ctrl.beq & alu_zero) | (ctrl.bne & ~alu_zero);

   always_comb begin
      pc_next = pc_plus4;
      if (ctrl.jump) begin
         pc_next = {pc_plus4[31:28], target, 2'b00};
      end else if (br_taken) begin
         pc_next = br_tgt;
      end
   end

   assign pc_d = initialize ? '0 : (pc_next & PC_MASK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 32; k++) begin
            rf_q[k] <= 32'(k);
         end
      end else if (run && ctrl.reg_we && (wr_reg != 5'd0)) begin
         rf_q[wr_reg] <= wb_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DMEM_DEPTH; k++) begin
            dmem_q[k] <= '0;
         end
      end else if (run && ctrl.mem_we) begin
         dmem_q[dm_idx] <= rt_val;
      end
   end

   // Program loading is independent of reset so code survives a core reset.
   assign im_wr_idx = instruction_initialize_address[IAW+1:2];

   always_ff @(posedge clk) begin
      if (initialize) begin
         imem_q[im_wr_idx] <= instruction_initialize_data;
      end
   end

   assign unused_ok = ^{instr[10:6],
                        instruction_initialize_address[31:IAW+2],
                        instruction_initialize_address[1:0]};

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed scenarios plus random programs, checked against
// an instruction-level model of the ISA kept in the bench.
module tb_cpu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        initialize = 1'b0;
   logic [31:0] init_data = '0;
   logic [31:0] init_addr = '0;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc;
   logic [31:0] m_rf [32];
   logic [31:0] m_dm [64];
   logic [31:0] m_im [64];
   logic [31:0] prog [$];

   always #5 clk = ~clk;

   cpu #(
      .IMEM_DEPTH (64),
      .DMEM_DEPTH (64)
   ) dut (
      .clk                            (clk),
      .rst                            (rst),
      .initialize                     (initialize),
      .instruction_initialize_data    (init_data),
      .instruction_initialize_address (init_addr)
   );

   function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
   endfunction

   function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0]  s;
      logic [4:0]  t;
      logic [4:0]  d;
      logic [15:0] off;
      logic [31:0] w;
      s   = 5'($urandom_range(0, 7));
      t   = 5'($urandom_range(0, 7));
      d   = 5'($urandom_range(0, 7));
      off = 16'($urandom_range(0, 16)) - 16'd8;
      case ($urandom_range(0, 12))
         0:       w = enc_r(s, t, d, 6'h20);
         1:       w = enc_r(s, t, d, 6'h22);
         2:       w = enc_r(s, t, d, 6'h24);
         3:       w = enc_r(s, t, d, 6'h25);
         4:       w = enc_r(s, t, d, 6'h2A);
         5:       w = enc_i(6'h08, s, t, 16'($urandom));
         6:       w = enc_i(6'h0F, s, t, 16'($urandom));
         7:       w = enc_i(6'h23, s, t, 16'($urandom));
         8:       w = enc_i(6'h2B, s, t, 16'($urandom));
         9:       w = enc_i(6'h04, s, t, off);
         10:      w = enc_i(6'h05, s, t, off);
         11:      w = enc_j(26'($urandom));
         default: w = $urandom;
      endcase
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int k = 0; k < 32; k++) m_rf[k] = 32'(k);
      for (int k = 0; k < 64; k++) m_dm[k] = 0;
   endtask

   task automatic model_step();
      logic [31:0] ins, a, b, se, ea, npc, res;
      logic [5:0]  op, fn;
      logic [4:0]  dst;
      logic        we;
      ins = m_im[(m_pc / 4) % 64];
      op  = ins[31:26];
      fn  = ins[5:0];
      a   = m_rf[ins[25:21]];
      b   = m_rf[ins[20:16]];
      se  = {{16{ins[15]}}, ins[15:0]};
      ea  = a + se;
      npc = m_pc + 4;
      dst = ins[20:16];
      we  = 1'b0;
      res = 0;
      case (op)
         6'h00: begin
            dst = ins[15:11];
            we  = 1'b1;
            case (fn)
               6'h20:   res = a + b;
               6'h22:   res = a - b;
               6'h24:   res = a & b;
               6'h25:   res = a | b;
               6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: we = 1'b0;
            endcase
         end
         6'h08: begin we = 1'b1; res = ea; end
         6'h0F: begin we = 1'b1; res = {ins[15:0], 16'h0000}; end
         6'h23: begin we = 1'b1; res = m_dm[(ea / 4) % 64]; end
         6'h2B: m_dm[(ea / 4) % 64] = b;
         6'h04: if (a == b) npc = npc + se * 4;
         6'h05: if (a != b) npc = npc + se * 4;
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         default: ;
      endcase
      if (we && dst != 0) m_rf[dst] = res;
      m_pc = npc % 256;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".pc"}, dut.pc_q, m_pc);
      for (int k = 0; k < 32; k++)
         chk($sformatf("%s.R%0d", tag, k), dut.rf_q[k], m_rf[k]);
      for (int k = 0; k < 64; k++)
         chk($sformatf("%s.dmem%0d", tag, k), dut.dmem_q[k], m_dm[k]);
   endtask

   task automatic check_imem(input string tag);
      for (int k = 0; k < 64; k++)
         chk($sformatf("%s.imem%0d", tag, k), dut.imem_q[k], m_im[k]);
   endtask

   task automatic load_prog();
      logic [31:0] w;
      @(negedge clk);
      initialize = 1'b1;
      for (int i = 0; i < 64; i++) begin
         w = (i < prog.size()) ? prog[i] : 32'h0;
         init_data = w;
         init_addr = 32'(i * 4) | 32'($urandom_range(0, 3)) | ({$urandom} << 8);
         m_im[i] = w;
         @(negedge clk);
      end
      initialize = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      check_state(tag);
   endtask

   task automatic run(input int n, input string tag);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         model_step();
         chk($sformatf("%s.pc@%0d", tag, c), dut.pc_q, m_pc);
      end
      check_state(tag);
   endtask

   initial begin
      #2 rst = 1'b0;
      model_reset();

      prog = '{enc_i(6'h2B, 0, 9, 16'd12), enc_i(6'h08, 17, 2, 16'd8),
               32'h0, enc_i(6'h0F, 0, 9, 16'd9), enc_i(6'h08, 17, 2, 16'd8),
               enc_i(6'h04, 0, 0, 16'hFFFF)};
      load_prog();
      check_state("t1.reset");
      rst = 1'b1;
      run(10, "t1");
      chk("t1.dmem3", dut.dmem_q[3], 32'd9);
      chk("t1.R2", dut.rf_q[2], 32'd25);
      chk("t1.R9", dut.rf_q[9], 32'h0009_0000);
      chk("t1.halt_pc", dut.pc_q, 32'd20);

      do_reset("t2.reset");
      prog = '{enc_r(0, 2, 1, 6'h20), enc_r(4, 4, 8, 6'h22),
               enc_r(5, 6, 7, 6'h25), enc_r(1, 4, 3, 6'h2A),
               enc_i(6'h04, 0, 0, 16'hFFFF)};
      load_prog();
      rst = 1'b1;
      run(8, "t2");
      chk("t2.R1", dut.rf_q[1], 32'd2);
      chk("t2.R8", dut.rf_q[8], 32'd0);
      chk("t2.R7", dut.rf_q[7], 32'd7);
      chk("t2.R3", dut.rf_q[3], 32'd1);

      do_reset("t3.reset");
      prog = '{enc_i(6'h2B, 0, 9, 16'd12), enc_i(6'h23, 0, 12, 16'd12),
               enc_i(6'h08, 0, 0, 16'd5), enc_i(6'h04, 0, 0, 16'hFFFF)};
      load_prog();
      rst = 1'b1;
      run(6, "t3");
      chk("t3.R12", dut.rf_q[12], 32'd9);
      chk("t3.R0", dut.rf_q[0], 32'd0);

      do_reset("t4.reset");
      prog = '{enc_i(6'h05, 0, 2, 16'd1), enc_i(6'h05, 0, 0, 16'd1),
               enc_j(26'd1)};
      load_prog();
      rst = 1'b1;
      run(1, "t4a");
      chk("t4.bne_taken", dut.pc_q, 32'd8);
      run(1, "t4b");
      chk("t4.jump", dut.pc_q, 32'd4);
      run(1, "t4c");
      chk("t4.bne_not_taken", dut.pc_q, 32'd8);

      do_reset("t5.pre");
      prog = '{enc_i(6'h2B, 0, 9, 16'd12), enc_i(6'h08, 17, 2, 16'd8),
               32'h0, enc_i(6'h0F, 0, 9, 16'd9), enc_i(6'h08, 17, 2, 16'd8),
               enc_i(6'h04, 0, 0, 16'hFFFF)};
      load_prog();
      rst = 1'b1;
      run(8, "t5.run");
      #2 rst = 1'b0;
      #1;
      model_reset();
      chk("t5.async_pc", dut.pc_q, 32'd0);
      chk("t5.async_R9", dut.rf_q[9], 32'd9);
      chk("t5.async_dmem3", dut.dmem_q[3], 32'd0);
      check_state("t5.async");
      check_imem("t5");
      @(posedge clk);
      #1;
      chk("t5.held_pc", dut.pc_q, 32'd0);

      @(negedge clk);
      rst = 1'b1;
      run(8, "t6.run");
      @(negedge clk);
      initialize = 1'b1;
      for (int c = 0; c < 10; c++) begin
         int idx;
         idx = $urandom_range(0, 63);
         init_addr = 32'(idx * 4);
         init_data = $urandom;
         @(posedge clk);
         #1;
         m_im[idx] = init_data;
         m_pc = 0;
         chk($sformatf("t6.load_pc@%0d", c), dut.pc_q, 32'd0);
         @(negedge clk);
      end
      initialize = 1'b0;
      check_state("t6.frozen");
      check_imem("t6");
      run(30, "t6.resume");

      for (int it = 0; it < 6; it++) begin
         do_reset($sformatf("rnd%0d.reset", it));
         prog.delete();
         for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
         load_prog();
         rst = 1'b1;
         run(120, $sformatf("rnd%0d", it));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
